dmac_channel_ctrl: RTL
======================

// Module: dmac_channel_ctrl
// PURPOSE
//  Channel sequencer directly upstream of the per-channel FIFO strobe decoder.
//  - Round-robin arbitrates among up to 6 requesting DMA channels.
//  - Drives DMACActivedChannel plus one shared set of FIFOReset/WriteDataEnable/ReadDataEnable
//    strobes; the decoder steers the strobes to the selected channel's FIFO.
//  - Per grant: flushes that channel's FIFO, fills it with BURST_LEN source beats, then drains
//    BURST_LEN beats to the destination.
// PARAMETERS
//  NUM_CH     6   channels served; max 7, so code 3'b111 remains free as "none"
//  BURST_LEN  8   beats per fill and per drain phase; range 1..255
//  CNT_W      $clog2(BURST_LEN+1)   beat counter width (derived)
// PORTS
//  clk                 in   1       single clock, rising edge
//  rst                 in   1       synchronous, active-high reset
//  ChannelRequest      in   NUM_CH  per-channel transfer request (level)
//  ChannelEnable       in   NUM_CH  per-channel enable; drop = abort
//  SrcDataValid        in   1       source beat available this cycle
//  DstReady            in   1       destination accepts a beat this cycle
//  DMACActivedChannel  out  3       active channel index; 3'b111 = none
//  FIFOReset           out  1       one-cycle flush of active channel FIFO
//  WriteDataEnable     out  1       push beat into active FIFO (= source pop)
//  ReadDataEnable      out  1       pop beat from active FIFO (= dest push)
//  ChannelDone         out  NUM_CH  one-hot, one-cycle pulse on completion
//  ChannelAbort        out  NUM_CH  one-hot, one-cycle pulse on abort
//  Busy                out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, DMACActivedChannel=3'b111, LastGrant=NUM_CH-1, BeatCnt=0;
//    all strobes, ChannelDone, ChannelAbort and Busy are 0.
//  Reset asserted mid-transfer: return to these values on the next edge; no Done/Abort pulse.
//  States: IDLE -> FLUSH -> FILL -> DRAIN -> DONE -> IDLE; ABORT reachable from FLUSH/FILL/DRAIN.
//  IDLE:  elig = ChannelRequest & ChannelEnable.
//    If elig!=0, register the round-robin winner (first set bit searching from LastGrant+1,
//      wrapping at NUM_CH) into DMACActivedChannel and LastGrant; go to FLUSH.
//  FLUSH: FIFOReset=1 for exactly one cycle; BeatCnt<=0; go to FILL.
//  FILL:  WriteDataEnable = SrcDataValid (combinational); BeatCnt increments on each beat.
//    Go to DRAIN on the cycle the BURST_LEN-th beat is accepted; BeatCnt<=0.
//  DRAIN: ReadDataEnable = DstReady (combinational); same count rule; go to DONE after the
//    BURST_LEN-th beat.
//  DONE:  ChannelDone[ch]=1 for one cycle; next edge state=IDLE, DMACActivedChannel=3'b111.
//  ABORT: ChannelEnable[ch] low in FLUSH/FILL/DRAIN -> next state ABORT.
//    Strobes forced 0 in the detecting cycle.
//    ABORT drives FIFOReset=1 and ChannelAbort[ch]=1 for one cycle, then IDLE with
//    DMACActivedChannel=3'b111.
//  Request drop while enabled does not abort; the burst completes.
//  Latency: request seen in IDLE -> FIFOReset 1 cycle later -> first WriteDataEnable no
//    earlier than 2 cycles later.
//  Minimum transfer is 2*BURST_LEN+3 cycles from the IDLE grant to return to IDLE.
//  Simultaneous events:
//    - New requests during a transfer are held off until IDLE.
//    - Re-arbitration occurs the cycle after DONE/ABORT, with no back-to-back grant in DONE.
//    - Same channel re-granted only if no other channel is eligible.
//  Never assert more than one of FIFOReset/WriteDataEnable/ReadDataEnable in a cycle.
//  BeatCnt never exceeds BURST_LEN.
// STRUCTURE
//  dmac_pkg: state enum {IDLE,FLUSH,FILL,DRAIN,DONE,ABORT}, CH_NONE=3'b111, CH_IDX_W=3.
//  Sub-module dmac_rr_arbiter (NUM_CH):
//    - inputs: elig vector, LastGrant
//    - outputs: GrantValid, GrantIdx
//    - purely combinational
//  FSM, beat counter and output logic stay in dmac_channel_ctrl.
// TESTING
//  1. rst high 3 cycles mid-FILL -> all outputs at reset values, DMACActivedChannel=3'b111,
//     no Done pulse.
//  2. Req/En ch2 only, SrcDataValid and DstReady tied 1, BURST_LEN=8:
//     FIFOReset@t+1, 8 WE t+2..t+9, 8 RE t+10..t+17, ChannelDone=6'b000100 @t+18.
//  3. Req on ch0,ch3,ch5 held:
//     grants 0,3,5,0, with LastGrant wrap verified from 5 to 0.
//  4. SrcDataValid toggling 1,0,1,0 in FILL:
//     WE mirrors SrcDataValid; exactly 8 WE pulses before DRAIN.
//  5. ChannelEnable[4] dropped after 3 RE beats:
//     ABORT cycle with FIFOReset=1, ChannelAbort=6'b010000; then IDLE, channel 3'b111.
//  6. Every cycle of tests 2-5:
//     assert at most one strobe high and BeatCnt<=BURST_LEN.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA channel sequencer.
package dmac_pkg;

  // Channel index width; the all-ones code is reserved to mean "no channel".
  localparam int CH_IDX_W = 3;
  localparam logic [CH_IDX_W-1:0] CH_NONE = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } dmacState_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible channel
// after the previously granted one, wrapping at NUM_CH.
module dmac_rr_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic [NUM_CH-1:0]   elig,
  input  logic [CH_IDX_W-1:0] LastGrant,
  output logic                GrantValid,
  output logic [CH_IDX_W-1:0] GrantIdx
);

  int                  candSum;
  logic [CH_IDX_W-1:0] candIdx;

  // Walk the channels starting at LastGrant+1; the first set bit wins, so the
  // previous winner is only reconsidered after every other channel.
  always_comb begin
    GrantValid = 1'b0;
    GrantIdx   = CH_NONE;
    candSum    = 0;
    candIdx    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      candSum = int'(LastGrant) + i;
      if (candSum >= NUM_CH) begin
        candSum = candSum - NUM_CH;
      end
      candIdx = CH_IDX_W'(candSum);
      if (!GrantValid && elig[candIdx]) begin
        GrantValid = 1'b1;
        GrantIdx   = candIdx;
      end
    end
  end

endmodule

// File: rtl/dmac_channel_ctrl.sv
// Per-grant DMA channel sequencer: arbitrate, flush, fill, drain, report.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no channel active; arbitrate among requesting, enabled channels
// FLUSH | one-cycle FIFOReset of the granted channel's FIFO
// FILL  | push BURST_LEN source beats (WriteDataEnable follows SrcDataValid)
// DRAIN | pop BURST_LEN beats to destination (ReadDataEnable follows DstReady)
// DONE  | one-cycle ChannelDone pulse, release the channel
// ABORT | enable dropped mid-transfer: flush FIFO, ChannelAbort pulse, release
module dmac_channel_ctrl
  import dmac_pkg::*;
#(
  parameter int NUM_CH    = 6,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ChannelRequest,
  input  logic [NUM_CH-1:0]   ChannelEnable,
  input  logic                SrcDataValid,
  input  logic                DstReady,
  output logic [CH_IDX_W-1:0] DMACActivedChannel,
  output logic                FIFOReset,
  output logic                WriteDataEnable,
  output logic                ReadDataEnable,
  output logic [NUM_CH-1:0]   ChannelDone,
  output logic [NUM_CH-1:0]   ChannelAbort,
  output logic                Busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  dmacState_t          state;
  dmacState_t          nextState;
  logic [CH_IDX_W-1:0] lastGrant;
  logic [CNT_W-1:0]    beatCnt;

  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   chOneHot;
  logic                grantValid;
  logic [CH_IDX_W-1:0] grantIdx;
  logic                inXfer;
  logic                chEnabled;
  logic                abortNow;
  logic                fillBeat;
  logic                drainBeat;
  logic                beatIsLast;

  assign elig = ChannelRequest & ChannelEnable;

  dmac_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .elig       (elig),
    .LastGrant  (lastGrant),
    .GrantValid (grantValid),
    .GrantIdx   (grantIdx)
  );

  // Active channel as a one-hot mask; all zero while no channel is held, so
  // the enable lookup never indexes outside the channel vector.
  always_comb begin
    chOneHot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chOneHot[i] = (DMACActivedChannel == CH_IDX_W'(i));
    end
  end

  assign inXfer     = (state == FLUSH) || (state == FILL) || (state == DRAIN);
  assign chEnabled  = |(ChannelEnable & chOneHot);
  assign abortNow   = inXfer && !chEnabled;
  assign fillBeat   = (state == FILL) && chEnabled && SrcDataValid;
  assign drainBeat  = (state == DRAIN) && chEnabled && DstReady;
  assign beatIsLast = (beatCnt == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode; an enable drop beats any beat-count transition.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantValid) nextState = FLUSH;
      end
      FLUSH: begin
        nextState = abortNow ? ABORT : FILL;
      end
      FILL: begin
        if (abortNow) begin
          nextState = ABORT;
        end else if (fillBeat && beatIsLast) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (abortNow) begin
          nextState = ABORT;
        end else if (drainBeat && beatIsLast) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      ABORT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode; strobes are suppressed in the cycle an abort is detected,
  // and only one of the three FIFO strobes can ever be active per state.
  always_comb begin
    FIFOReset       = ((state == FLUSH) && !abortNow) || (state == ABORT);
    WriteDataEnable = fillBeat;
    ReadDataEnable  = drainBeat;
    ChannelDone     = (state == DONE)  ? chOneHot : '0;
    ChannelAbort    = (state == ABORT) ? chOneHot : '0;
    Busy            = (state != IDLE);
  end

  // Grant capture, channel release and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      DMACActivedChannel <= CH_NONE;
      lastGrant          <= CH_IDX_W'(NUM_CH - 1);
      beatCnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            DMACActivedChannel <= grantIdx;
            lastGrant          <= grantIdx;
          end
        end
        FLUSH: begin
          beatCnt <= '0;
        end
        FILL: begin
          if (fillBeat) beatCnt <= beatIsLast ? '0 : beatCnt + 1'b1;
        end
        DRAIN: begin
          if (drainBeat) beatCnt <= beatIsLast ? '0 : beatCnt + 1'b1;
        end
        DONE: begin
          DMACActivedChannel <= CH_NONE;
        end
        ABORT: begin
          DMACActivedChannel <= CH_NONE;
          beatCnt            <= '0;
        end
        default: begin
          DMACActivedChannel <= CH_NONE;
        end
      endcase
    end
  end

endmodule
